// File: rtl/video_ram_term_writer.sv
// Terminal-style writer for a byte-addressed text video RAM.
// Turns an ASCII byte stream into RAM cell writes, tracks a cursor,
// interprets CR/LF/BS/FF and blanks the screen or the entered row as needed.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_data     input byte stream; accepted when in_valid & in_ready
//   in_ready             high in IDLE unless clear_req is asserted
//   clear_req            level request for a full-screen clear (sampled in IDLE)
//   wr_ce/wr_ad/wr_data  registered RAM write port, one cycle per cell
//   cur_col/cur_row      cursor position
//   busy                 high while a screen or line clear is running
module video_ram_term_writer #(
   parameter int unsigned COLS   = 64,
   parameter int unsigned ROWS   = 32,
   parameter int unsigned ADDR_W = 11,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   output logic                     in_ready,
   input  logic                     clear_req,
   output logic                     wr_ce,
   output logic [ADDR_W-1:0]        wr_ad,
   output logic [7:0]               wr_data,
   output logic [$clog2(COLS)-1:0]  cur_col,
   output logic [$clog2(ROWS)-1:0]  cur_row,
   output logic                     busy
);

   localparam int unsigned CW    = $clog2(COLS);
   localparam int unsigned RW    = $clog2(ROWS);
   localparam int unsigned PW    = CW + RW;
   localparam int unsigned CELLS = COLS * ROWS;

   typedef enum logic [1:0] {
      S_CLEAR_ALL  = 2'd0,
      S_IDLE       = 2'd1,
      S_CLEAR_LINE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic                wr_ce_q, wr_ce_d;
   logic [ADDR_W-1:0]   wr_ad_q, wr_ad_d;
   logic [7:0]          wr_data_q, wr_data_d;
   logic [RW-1:0]       row_next;
   logic                accept;

   assign in_ready = (state_q == S_IDLE) & ~clear_req;
   assign accept   = in_valid & in_ready;
   assign busy     = (state_q != S_IDLE);
   assign wr_ce    = wr_ce_q;
   assign wr_ad    = wr_ad_q;
   assign wr_data  = wr_data_q;
   assign cur_col  = col_q;
   assign cur_row  = row_q;

   // Row advance with wrap-around (no scrolling)
   assign row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

   // Next-state and write generation
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      col_d     = col_q;
      row_d     = row_q;
      wr_ce_d   = 1'b0;
      wr_ad_d   = wr_ad_q;
      wr_data_d = wr_data_q;

      case (state_q)
         S_CLEAR_ALL: begin
            wr_ce_d   = 1'b1;
            wr_ad_d   = ADDR_W'(ptr_q);
            wr_data_d = BLANK;
            col_d     = '0;
            row_d     = '0;
            ptr_d     = ptr_q + PW'(1);
            if (ptr_q == PW'(CELLS - 1)) begin
               ptr_d   = '0;
               state_d = S_IDLE;
            end
         end

         S_CLEAR_LINE: begin
            // Low pointer bits walk the columns of the current row
            wr_ce_d   = 1'b1;
            wr_ad_d   = ADDR_W'({row_q, ptr_q[CW-1:0]});
            wr_data_d = BLANK;
            ptr_d     = ptr_q + PW'(1);
            if (ptr_q[CW-1:0] == CW'(COLS - 1)) begin
               ptr_d   = '0;
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            if (clear_req) begin
               ptr_d   = '0;
               state_d = S_CLEAR_ALL;
            end else if (accept) begin
               if (in_data == 8'h0D) begin
                  col_d = '0;
               end else if (in_data == 8'h0A) begin
                  row_d   = row_next;
                  ptr_d   = '0;
                  state_d = S_CLEAR_LINE;
               end else if (in_data == 8'h08) begin
                  if (col_q != '0) begin
                     col_d     = col_q - CW'(1);
                     wr_ce_d   = 1'b1;
                     wr_ad_d   = ADDR_W'({row_q, col_q - CW'(1)});
                     wr_data_d = BLANK;
                  end
               end else if (in_data == 8'h0C) begin
                  col_d   = '0;
                  row_d   = '0;
                  ptr_d   = '0;
                  state_d = S_CLEAR_ALL;
               end else if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
                  wr_ce_d   = 1'b1;
                  wr_ad_d   = ADDR_W'({row_q, col_q});
                  wr_data_d = in_data;
                  col_d     = col_q + CW'(1);
                  // Last column: wrap to the next row and blank it
                  if (col_q == CW'(COLS - 1)) begin
                     col_d   = '0;
                     row_d   = row_next;
                     ptr_d   = '0;
                     state_d = S_CLEAR_LINE;
                  end
               end
            end
         end

         default: begin
            ptr_d   = '0;
            state_d = S_CLEAR_ALL;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_CLEAR_ALL;
         ptr_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         wr_ce_q   <= 1'b0;
         wr_ad_q   <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         col_q     <= col_d;
         row_q     <= row_d;
         wr_ce_q   <= wr_ce_d;
         wr_ad_q   <= wr_ad_d;
         wr_data_q <= wr_data_d;
      end
   end

endmodule
